// File: rtl/sev_seg_pkg.sv
// Shared 7-segment constants: active-low hex segment table and a polarity helper.
package sev_seg_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_NUM [0:15] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  // Table is native active-low; flip it for active-high boards.
  function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit active_low);
    return active_low ? seg : ~seg;
  endfunction

endpackage

// File: rtl/sev_seg_scan_tick.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last count of each slot.
module sev_seg_scan_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  // Free-running slot counter, wraps at DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sev_seg_scan_drv.sv
// Time-multiplexed hex 7-segment driver with a shadow/display double buffer.
// Shadow data is committed to the display only at frame ends so a frame never
// mixes old and new digits. Optional leading-zero suppression is built when
// SEV_SEG_LZ_BLANK_EN is defined (adds the lz_en input).
module sev_seg_scan_drv
  import sev_seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
`ifdef SEV_SEG_LZ_BLANK_EN
  input  logic                  lz_en,
`endif
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
  localparam bit AL = (ACTIVE_LOW != 0);

  logic                  tick;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shd_val_q, dsp_val_q;
  logic [N_DIGITS-1:0]   shd_blk_q, dsp_blk_q, shd_dp_q, dsp_dp_q;
  logic                  pending_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_lit;
  logic [N_DIGITS-1:0]   an_q, oh_d;
  logic [3:0]            nib;
  logic                  lz_sup, dark;

  sev_seg_scan_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign frame_done = tick && (idx_q == LAST);
  assign pending    = pending_q;
  assign idx_d      = (idx_q == LAST) ? '0 : idx_q + 1'b1;

  // Digit index steps once per slot.
  always_ff @(posedge clk) begin
    if (!rst_n)    idx_q <= '0;
    else if (tick) idx_q <= idx_d;
  end

  // Shadow capture and frame-boundary commit; a load on the boundary bypasses the shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_val_q <= '0; shd_blk_q <= '0; shd_dp_q <= '0;
      dsp_val_q <= '0; dsp_blk_q <= '0; dsp_dp_q <= '0;
      pending_q <= 1'b0;
    end else begin
      if (load) begin
        shd_val_q <= value; shd_blk_q <= blank_mask; shd_dp_q <= dp_mask;
      end
      if (frame_done) begin
        if (load) begin
          dsp_val_q <= value; dsp_blk_q <= blank_mask; dsp_dp_q <= dp_mask;
        end else if (pending_q) begin
          dsp_val_q <= shd_val_q; dsp_blk_q <= shd_blk_q; dsp_dp_q <= shd_dp_q;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end
    end
  end

`ifdef SEV_SEG_LZ_BLANK_EN
  // Suppress the current digit if it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic zrun;
    zrun   = 1'b1;
    lz_sup = 1'b0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zrun = zrun && (dsp_val_q[4*k +: 4] == 4'h0);
      if (lz_en && zrun && (idx_q == IW'(k))) lz_sup = 1'b1;
    end
  end
`else
  assign lz_sup = 1'b0;
`endif

  // Decode the selected digit in native polarity; a dark digit drives nothing.
  always_comb begin
    nib    = dsp_val_q[{idx_q, 2'b00} +: 4];
    dark   = dsp_blk_q[idx_q] | lz_sup;
    seg_d  = dark ? SEG_OFF : SEG_NUM[nib];
    dp_lit = !dark && dsp_dp_q[idx_q];
    oh_d   = '0;
    if (!dark) oh_d[idx_q] = 1'b1;
  end

  // Output registers: seg, dp and anode all move on the same edge to avoid ghosting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= seg_pol(SEG_OFF, AL);
      dp_q  <= AL;
      an_q  <= {N_DIGITS{AL}};
    end else begin
      seg_q <= seg_pol(seg_d, AL);
      dp_q  <= AL ? ~dp_lit : dp_lit;
      an_q  <= AL ? ~oh_d : oh_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_sev_seg_scan_drv.sv
// Directed bench for sev_seg_scan_drv with N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
module tb_sev_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;
  logic        pending;
`ifdef SEV_SEG_LZ_BLANK_EN
  logic        lz_en = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, SA = 7'b0001000,
                         SF = 7'b0001110, SOFF = 7'b1111111;

  sev_seg_scan_drv #(.N_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
`ifdef SEV_SEG_LZ_BLANK_EN
    .lz_en      (lz_en),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge where frame_done is high, bounded.
  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    chk(tag, {31'b0, frame_done}, 32'd1);
  endtask

  task automatic chk_dig(input string tag, input logic [6:0] seg, input logic [3:0] an);
    chk({tag, "_seg"}, {25'b0, seg_out}, {25'b0, seg});
    chk({tag, "_an"},  {28'b0, an_out},  {28'b0, an});
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_an",  {28'b0, an_out}, 32'hF);
    chk("rst_seg", {25'b0, seg_out}, 32'h7F);
    chk("rst_dp",  {31'b0, dp_out}, 32'd1);
    chk("rst_pend", {31'b0, pending}, 32'd0);
    chk("rst_fd",  {31'b0, frame_done}, 32'd0);

    // Release: first output update shows digit 0 = '0'
    rst_n = 1'b1;
    step(1);
    chk_dig("rel_d0", S0, 4'b1110);
    chk("rel_dp", {31'b0, dp_out}, 32'd1);

    // Load 1A2F mid-frame; committed at frame end
    load = 1'b1; value = 16'h1A2F;
    step(1);
    load = 1'b0;
    chk("ld_pend", {31'b0, pending}, 32'd1);
    wait_fd("fd1");
    chk_dig("old_d3", S0, 4'b0111);
    chk("fd1_pend", {31'b0, pending}, 32'd1);
    step(1);
    chk("commit_pend", {31'b0, pending}, 32'd0);
    step(1); chk_dig("new_d0", SF, 4'b1110);
    step(4); chk_dig("new_d1", S2, 4'b1101);
    step(4); chk_dig("new_d2", SA, 4'b1011);
    step(4); chk_dig("new_d3", S1, 4'b0111);

    // Two loads in one frame: last wins
    wait_fd("fd2");
    step(1);
    load = 1'b1; value = 16'h1111;
    step(1);
    value = 16'h2222;
    step(1);
    load = 1'b0;
    chk("dbl_pend", {31'b0, pending}, 32'd1);
    wait_fd("fd3");
    step(2); chk_dig("dbl_d0", S2, 4'b1110);
    step(4); chk_dig("dbl_d1", S2, 4'b1101);

    // Load coincident with frame_done goes straight to display
    wait_fd("fd4");
    load = 1'b1; value = 16'h4321;
    step(1);
    load = 1'b0;
    chk("coin_pend0", {31'b0, pending}, 32'd0);
    step(1);
    chk_dig("coin_d0", S1, 4'b1110);
    chk("coin_pend1", {31'b0, pending}, 32'd0);

    // Blank digit 2, dp on digit 0
    load = 1'b1; value = 16'h4321; blank_mask = 4'b0100; dp_mask = 4'b0001;
    step(1);
    load = 1'b0;
    wait_fd("fd5");
    step(2); chk_dig("bl_d0", S1, 4'b1110);
    chk("bl_dp0", {31'b0, dp_out}, 32'd0);
    step(4); chk_dig("bl_d1", S2, 4'b1101);
    chk("bl_dp1", {31'b0, dp_out}, 32'd1);
    step(4); chk_dig("bl_d2", SOFF, 4'b1111);
    chk("bl_dp2", {31'b0, dp_out}, 32'd1);
    step(4); chk_dig("bl_d3", S4, 4'b0111);

`ifdef SEV_SEG_LZ_BLANK_EN
    // Leading-zero suppression
    lz_en = 1'b1;
    load = 1'b1; value = 16'h0030; blank_mask = 4'b0000; dp_mask = 4'b0000;
    step(1);
    load = 1'b0;
    wait_fd("fd_lz1");
    step(2); chk_dig("lz_d0", S0, 4'b1110);
    step(4); chk_dig("lz_d1", S3, 4'b1101);
    step(4); chk_dig("lz_d2", SOFF, 4'b1111);
    step(4); chk_dig("lz_d3", SOFF, 4'b1111);
    step(1);
    load = 1'b1; value = 16'h0000;
    step(1);
    load = 1'b0;
    wait_fd("fd_lz2");
    step(2); chk_dig("lz0_d0", S0, 4'b1110);
    step(4); chk_dig("lz0_d1", SOFF, 4'b1111);
`endif

    // Reset mid-frame discards pending data and clears the display
    load = 1'b1; value = 16'hFFFF; blank_mask = 4'b0000;
    step(1);
    load = 1'b0;
    chk("mid_pend1", {31'b0, pending}, 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("mid_pend0", {31'b0, pending}, 32'd0);
    chk_dig("mid_rst", SOFF, 4'b1111);
    rst_n = 1'b1;
    step(1);
    chk_dig("mid_rel", S0, 4'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_drv.md
Name: sev_seg_scan_drv

Overview:
Parametrised, time-multiplexed driver for N common-anode or common-cathode hex 7-segment digits.
- Holds a double-buffered hex word and scans the digits one at a time at a programmable refresh rate.
- Decodes each nibble to segments, with per-digit blanking and decimal points.
- Sits between CPU debug/IO registers and the board display pins.
- Display updates are tear-free: new data is committed only at frame boundaries.

Parameters:
- N_DIGITS, 4, number of digits scanned (legal 1..8).
- REFRESH_DIV, 50000, clk cycles per digit slot (legal >= 2).
- ACTIVE_LOW, 1, 1 = seg/dp/anode outputs active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load  in  1  one-cycle strobe; captures value/blank_mask/dp_mask
- value  in  4*N_DIGITS  hex nibbles; digit 0 = bits [3:0]
- blank_mask  in  N_DIGITS  1 = digit dark
- dp_mask  in  N_DIGITS  1 = decimal point lit
- seg_out  out  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
- dp_out  out  1  decimal point, polarity per ACTIVE_LOW
- an_out  out  N_DIGITS  digit enables, one-hot active, polarity per ACTIVE_LOW
- frame_done  out  1  one-cycle pulse when the last digit slot ends
- pending  out  1  shadow data loaded but not yet committed

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low, sampled on the clk rising edge.
- Reset values:
  - prescaler = 0, digit index = 0, pending = 0, frame_done = 0.
  - shadow and display registers = 0.
  - seg_out, dp_out, an_out all inactive (all 1s when ACTIVE_LOW = 1).
- Reset mid-frame aborts the scan immediately and discards pending data.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted in the cycle where count = REFRESH_DIV-1.
- Digit index:
  - Advances on tick; wraps from N_DIGITS-1 to 0.
  - frame_done = tick AND index = N_DIGITS-1.
  - With N_DIGITS = 1, every tick is a frame end.
- Load:
  - On load, the shadow register captures value, blank_mask and dp_mask, and pending is set next cycle.
  - A load while pending = 1 overwrites the shadow (last write wins).
- Commit:
  - When frame_done is asserted with pending = 1, shadow is copied to display and pending clears.
  - Simultaneous load and frame_done: the current-cycle load data goes directly to display and pending stays 0.
- Output path:
  - Segment table is active-low native; inverted when ACTIVE_LOW = 0.
  - For a blanked digit: seg_out = all off, dp_out off, an_out all inactive.
  - Otherwise an_out drives only bit [index] active.
  - All outputs are registered, with one cycle of latency from the index/display change.
  - No ghosting: an_out changes in the same cycle as seg_out.

Optional Feature:
- Macro: SEV_SEG_LZ_BLANK_EN, leading-zero suppression.
- With the macro defined:
  - An added input lz_en (1 bit) is present.
  - When lz_en = 1, digit k is also blanked if every display nibble from N_DIGITS-1 down to k is 0.
  - Digit 0 is never suppressed.
  - The dp of a suppressed digit is also forced off.
- Without the macro: the lz_en port and its logic are absent, and only blank_mask blanks digits.

Decomposition:
- Package sev_seg_pkg holds:
  - SEG_NUM[0:15] active-low segment table;
  - SEG_OFF = 7'b1111111;
  - function seg_pol(logic [6:0], bit active_low).
- Sub-module sev_seg_scan_tick(DIV): prescaler plus tick output.
- Scan, buffering and output registers stay in the top module.

Test Plan:
- Reset, then release with N_DIGITS = 4, REFRESH_DIV = 4, value = 16'h0000:
  - expect an_out = 4'b1111 and seg_out = 7'h7F until first output register update;
  - then digit 0 active showing 7'b1000000.
- load value = 16'h1A2F, then run 2 frames:
  - frame 1 shows 0000 and pending = 1;
  - after frame_done, digits 0..3 show F(7'b0001110), 2(7'b0100100), A(7'b0001000), 1(7'b1111001);
  - an_out sequence 1110, 1101, 1011, 0111.
- Two loads (16'h1111, then 16'h2222) in one frame:
  - only 16'h2222 is committed at the boundary.
- load coincident with frame_done:
  - data appears in the next slot and pending never asserts.
- blank_mask = 4'b0100, dp_mask = 4'b0001:
  - digit 2 slot has an_out = 4'b1111;
  - digit 0 has dp_out = 0.
- SEV_SEG_LZ_BLANK_EN defined, lz_en = 1, value = 16'h0030:
  - digits 3 and 2 are dark, digits 1 and 0 show 3 and 0;
  - value = 16'h0000 shows only digit 0.
